// File: rtl/io_pad_ctrl_mc.sv
// Multi-core pad-ring controller: reset synchroniser, per-core straps and status,
// host halt/run request/acknowledge sequencer with ack timeout, and wake pulses.
module io_pad_ctrl_mc #(
    parameter int NUM_CORES       = 2,
    parameter int RST_SYNC_STAGES = 2,
    parameter int ARCNUM_BASE     = 0,
    parameter int TO_W            = 8,
    parameter int ACK_TIMEOUT     = 200
) (
    input  logic                   clk,
    input  logic                   erst_n,
    output logic                   rst_a,
    output logic                   orst_n,
    input  logic                   host_halt_req,
    input  logic                   host_run_req,
    input  logic [NUM_CORES-1:0]   host_core_mask,
    input  logic                   host_wake,
    output logic [NUM_CORES-1:0]   arc_halt_req_a,
    output logic [NUM_CORES-1:0]   arc_run_req_a,
    input  logic [NUM_CORES-1:0]   arc_halt_ack,
    input  logic [NUM_CORES-1:0]   arc_run_ack,
    output logic [NUM_CORES-1:0]   arc_wake_evt_a,
    input  logic [NUM_CORES-1:0]   sys_halt_r,
    input  logic [NUM_CORES-1:0]   sys_sleep_r,
    output logic [8*NUM_CORES-1:0] arcnum,
    output logic                   en,
    output logic                   test_mode,
    output logic                   ctrl_busy,
    output logic                   ctrl_done,
    output logic                   ctrl_timeout
);

    typedef enum logic [1:0] {IDLE, HALT_WAIT, RUN_WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic [RST_SYNC_STAGES-1:0] sync_q;
    state_t                     state_q, state_d;
    logic [NUM_CORES-1:0]       pend_q, pend_d;
    logic [NUM_CORES-1:0]       halt_q, halt_d;
    logic [NUM_CORES-1:0]       run_q, run_d;
    logic [TO_W-1:0]            timer_q, timer_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic [NUM_CORES-1:0]       wake_q;

    // Async assert, sync release: a 1 must walk the whole chain before rst_a drops
    always_ff @(posedge clk or negedge erst_n) begin
        if (!erst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_a  = ~sync_q[RST_SYNC_STAGES-1];
    assign orst_n = sync_q[RST_SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_arcnum
        assign arcnum[8*i +: 8] = 8'(ARCNUM_BASE + i);
    end

    assign en        = ~&sys_halt_r;
    assign test_mode = 1'b0;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        halt_d    = halt_q;
        run_d     = run_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (host_halt_req) begin
                    pend_d  = host_core_mask;
                    halt_d  = host_core_mask;
                    state_d = (host_core_mask == '0) ? DONE : HALT_WAIT;
                end else if (host_run_req) begin
                    pend_d  = host_core_mask;
                    run_d   = host_core_mask;
                    state_d = (host_core_mask == '0) ? DONE : RUN_WAIT;
                end
            end
            HALT_WAIT, RUN_WAIT: begin
                // Acks on cores not pending are masked off by pend
                if (state_q == HALT_WAIT) begin
                    pend_d = pend_q & ~arc_halt_ack;
                    halt_d = halt_q & ~arc_halt_ack;
                end else begin
                    pend_d = pend_q & ~arc_run_ack;
                    run_d  = run_q & ~arc_run_ack;
                end
                if (pend_d == '0) begin
                    state_d = DONE;
                end else if (timer_q == TO_LAST) begin
                    pend_d    = '0;
                    halt_d    = '0;
                    run_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                timer_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer is held idle for as long as the synchronised reset is asserted
    always_ff @(posedge clk or negedge erst_n) begin
        if (!erst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            halt_q    <= '0;
            run_q     <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (rst_a) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            halt_q    <= '0;
            run_q     <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            halt_q    <= halt_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk or negedge erst_n) begin
        if (!erst_n) begin
            wake_q <= '0;
        end else begin
            wake_q <= {NUM_CORES{host_wake}} & sys_sleep_r;
        end
    end

    assign arc_halt_req_a = halt_q;
    assign arc_run_req_a  = run_q;
    assign arc_wake_evt_a = wake_q;
    assign ctrl_busy      = (state_q != IDLE);
    assign ctrl_done      = done_q;
    assign ctrl_timeout   = timeout_q;

endmodule
